// File: rtl/mem_responder.sv
// Slave-side req/gnt/rvalid responder backed by a word-addressed byte-enable memory.
// Grant after GNT_WAIT held-request cycles; response exactly RSP_LATENCY cycles after the grant.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int GNT_WAIT    = 0,
  parameter int RSP_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o
);

  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int OFF     = $clog2(BE_W);
  localparam int WORD_AW = ADDR_WIDTH - OFF;
  localparam int DEPTH   = 2 ** WORD_AW;
  localparam int CW      = $clog2(GNT_WAIT + 2);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt;
  logic            xfer;
  logic [WORD_AW-1:0] word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [RSP_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0]  pipe_rdata [RSP_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    if (GNT_WAIT == 0) begin
      gnt     = data_req_i;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req_i) begin
            state_d = WAIT;
            cnt_d   = CW'(1);
          end
        end
        WAIT: begin
          // A dropped request abandons the wait without a transfer.
          if (!data_req_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(GNT_WAIT)) begin
            gnt     = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    gnt = gnt & ~reset;
  end

  assign data_gnt_o = gnt;
  assign xfer       = data_req_i & gnt;
  assign word       = data_addr_i[ADDR_WIDTH-1:OFF];

  // Memory is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (xfer && data_we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (data_be_i[b]) mem[word][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < RSP_LATENCY; i++) pipe_rdata[i] <= '0;
    end else begin
      pipe_vld[0]   <= xfer;
      pipe_rdata[0] <= (xfer && !data_we_i) ? mem[word] : '0;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  assign data_rvalid_o = pipe_vld[RSP_LATENCY-1] & ~reset;
  assign data_rdata_o  = data_rvalid_o ? pipe_rdata[RSP_LATENCY-1] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three configurations, scoreboard queues filled by the
// driver from a simple array memory model and drained by a negedge monitor.
module tb_mem_responder;

  localparam int GW0 = 0, RL0 = 1;
  localparam int GW1 = 2, RL1 = 2;
  localparam int GW2 = 0, RL2 = 3;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we, gnt, rvalid;
  logic [9:0]  addr  [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];

  logic [31:0] mdl [3][16];
  exp_t        expq [3][$];
  int          cyc   = 0;
  int          nvec  = 0;
  int          nbad  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .GNT_WAIT(GW0), .RSP_LATENCY(RL0)) dut0 (
    .clk(clk), .reset(reset), .data_req_i(req[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_wdata_i(wdata[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]),
    .data_rdata_o(rdata[0]));
  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .GNT_WAIT(GW1), .RSP_LATENCY(RL1)) dut1 (
    .clk(clk), .reset(reset), .data_req_i(req[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_wdata_i(wdata[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]),
    .data_rdata_o(rdata[1]));
  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .GNT_WAIT(GW2), .RSP_LATENCY(RL2)) dut2 (
    .clk(clk), .reset(reset), .data_req_i(req[2]), .data_addr_i(addr[2]), .data_we_i(we[2]),
    .data_be_i(be[2]), .data_wdata_i(wdata[2]), .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]),
    .data_rdata_o(rdata[2]));

  function automatic int gw(input int k);
    case (k)
      0:       return GW0;
      1:       return GW1;
      default: return GW2;
    endcase
  endfunction

  function automatic int rl(input int k);
    case (k)
      0:       return RL0;
      1:       return RL1;
      default: return RL2;
    endcase
  endfunction

  // Monitor: every response must match the oldest outstanding expectation, on its due cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (gnt[k] && (!req[k] || reset)) begin
        nbad++;
        $display("FAIL gnt_without_req dut%0d: gnt=1 req=%0b reset=%0b, required gnt=0", k, req[k], reset);
      end
      if (rvalid[k]) begin
        nvec++;
        if (expq[k].size() == 0) begin
          nbad++;
          $display("FAIL unexpected_rvalid dut%0d: rvalid=1 rdata=%h at cycle %0d, required no response", k, rdata[k], cyc);
        end else begin
          exp_t e;
          e = expq[k].pop_front();
          if (rdata[k] !== e.data || cyc != e.due) begin
            nbad++;
            $display("FAIL response dut%0d: rdata=%h cycle=%0d, required rdata=%h cycle=%0d", k, rdata[k], cyc, e.data, e.due);
          end
        end
      end else if (rdata[k] !== 32'h0) begin
        nbad++;
        $display("FAIL idle_rdata dut%0d: rdata=%h with rvalid=0, required 0", k, rdata[k]);
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic xfer(input int k, input logic w, input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
    int   waits;
    int   wi;
    exp_t e;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    waits = 0;
    #1;
    while (!gnt[k] && waits < 20) begin
      @(posedge clk); #2;
      waits++;
    end
    nvec++;
    if (!gnt[k]) begin
      nbad++;
      $display("FAIL gnt_timeout dut%0d: no gnt after %0d cycles, required gnt after %0d", k, waits, gw(k));
    end else begin
      if (waits != gw(k)) begin
        nbad++;
        $display("FAIL gnt_wait dut%0d: gnt after %0d cycles, required %0d", k, waits, gw(k));
      end
      wi    = int'(a[5:2]);
      e.due = cyc + rl(k);
      if (w) begin
        e.data = 32'h0;
        for (int bb = 0; bb < 4; bb++)
          if (b[bb]) mdl[k][wi][8*bb +: 8] = d[8*bb +: 8];
      end else begin
        e.data = mdl[k][wi];
      end
      expq[k].push_back(e);
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    we    = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    req = 3'b111;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0) begin
        nbad++;
        $display("FAIL reset_state dut%0d: gnt=%b rvalid=%b rdata=%h, required 0 0 0", k, gnt[k], rvalid[k], rdata[k]);
      end
    end
    req = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload the 16 modelled words of every instance.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        xfer(k, 1'b1, 10'(w * 4), 4'hF, $urandom);

    xfer(0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
    xfer(0, 1'b0, 10'h010, 4'h0, 32'h0);
    xfer(0, 1'b1, 10'h020, 4'hF, 32'h11223344);
    xfer(0, 1'b1, 10'h020, 4'b0101, 32'hAABBCCDD);
    xfer(0, 1'b0, 10'h020, 4'h0, 32'h0);
    xfer(0, 1'b1, 10'h024, 4'h0, 32'hFFFFFFFF);
    xfer(0, 1'b0, 10'h024, 4'h0, 32'h0);

    xfer(1, 1'b0, 10'h010, 4'h0, 32'h0);
    xfer(1, 1'b0, 10'h014, 4'h0, 32'h0);
    // Request dropped mid-wait: nothing transfers, next request pays the full wait.
    req[1] = 1'b1; addr[1] = 10'h018; we[1] = 1'b1; be[1] = 4'hF; wdata[1] = 32'hBAD0BAD0;
    idle(1);
    req[1] = 1'b0;
    idle(2);
    xfer(1, 1'b0, 10'h018, 4'h0, 32'h0);

    for (int w = 0; w < 4; w++) xfer(2, 1'b1, 10'(w * 4), 4'hF, 32'(w + 1));
    idle(4);
    for (int w = 0; w < 4; w++) xfer(2, 1'b0, 10'(w * 4), 4'h0, 32'h0);

    xfer(0, 1'b1, 10'h030, 4'hF, 32'h5A5A5A5A);
    xfer(0, 1'b0, 10'h031, 4'h0, 32'h0);
    xfer(2, 1'b1, 10'h030, 4'hF, 32'h5A5A5A5A);
    xfer(2, 1'b0, 10'h032, 4'h0, 32'h0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        logic [3:0] wi;
        logic [1:0] lo;
        wi = 4'($urandom_range(0, 15));
        lo = 2'($urandom_range(0, 3));
        xfer(k, 1'($urandom_range(0, 1)), {4'b0, wi, lo}, 4'($urandom), $urandom);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    idle(8);

    // Reset with two reads in flight on the latency-3 instance.
    xfer(2, 1'b0, 10'h000, 4'h0, 32'h0);
    xfer(2, 1'b0, 10'h004, 4'h0, 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) expq[k].delete();
    idle(2);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      nvec++;
      if (rvalid[2] !== 1'b0) begin
        nbad++;
        $display("FAIL dropped_after_reset: rvalid=%b at cycle %0d, required 0", rvalid[2], cyc);
      end
      idle(1);
    end

    // Reset while a grant wait is pending must restart the wait from scratch.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h010;
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    xfer(1, 1'b0, 10'h010, 4'h0, 32'h0);

    for (int w = 0; w < 16; w++) xfer(2, 1'b0, 10'(w * 4), 4'h0, 32'h0);

    for (int t = 0; t < 50; t++) begin
      if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) break;
      idle(1);
    end
    for (int k = 0; k < 3; k++) begin
      if (expq[k].size() != 0) begin
        nbad++;
        $display("FAIL missing_response dut%0d: %0d responses outstanding, required 0", k, expq[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
